// File: rtl/srt4_div_pkg.sv
// rtl/srt4_div_pkg.sv - shared types and constants for the radix-4 SRT divider sequencer
package srt4_div_pkg;

    localparam int W_WIDTH    = 22;  // residual / divisor width, MSB is the sign
    localparam int AB_WIDTH   = 26;  // on-the-fly quotient registers A (Q) and B (Q-1)
    localparam int IDX_WIDTH  = 4;   // iteration index width
    localparam int N_ITER_MAX = 12;  // step stage decodes idx 0..11

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient digit encoding, 3-bit two's complement
    localparam logic [2:0] Q_P2 = 3'b010;
    localparam logic [2:0] Q_P1 = 3'b001;
    localparam logic [2:0] Q_Z  = 3'b000;
    localparam logic [2:0] Q_M1 = 3'b111;
    localparam logic [2:0] Q_M2 = 3'b110;

endpackage

// File: rtl/srt4_digit_sel.sv
// rtl/srt4_digit_sel.sv - combinational radix-4 SRT quotient digit selection
//
// Ports:
//   w  in  W_WIDTH  current residual (two's complement)
//   d  in  W_WIDTH  divisor (two's complement)
//   q  out 3        selected digit: +2/+1/0/-1/-2 encoded as Q_P2..Q_M2
module srt4_digit_sel
    import srt4_div_pkg::*;
(
    input  logic [W_WIDTH-1:0] w,
    input  logic [W_WIDTH-1:0] d,
    output logic [2:0]         q
);

    // All compares are done at 24 bits so that t = 1.5*D cannot overflow.
    logic signed [23:0] s;
    logic signed [23:0] dx;
    logic signed [23:0] h;
    logic signed [23:0] t;

    always_comb begin
        // Shifted residual 4W: bits 20:19 are dropped, the sign bit is kept.
        s  = {{2{w[21]}}, w[21], w[18:0], 2'b00};
        dx = {{2{d[21]}}, d};
        h  = dx >>> 1;
        t  = dx + h;
        if (s >= t) begin
            q = Q_P2;
        end else if (s >= h) begin
            q = Q_P1;
        end else if (s > -h) begin
            q = Q_Z;
        end else if (s > -t) begin
            q = Q_M1;
        end else begin
            q = Q_M2;
        end
    end

endmodule

// File: rtl/srt4_div_seq.sv
// rtl/srt4_div_seq.sv - sequencer for the radix-4 SRT step datapath
//
// Optional feature macro: DIVZERO_CHECK_EN (zero-divisor short cut and div_err port).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, dividend, divisor    request and operands, taken when idle with no pending result
//   busy                        high from accept until the result handshake completes
//   dp_w, dp_q, dp_d            residual, digit and held divisor to the step stage
//   dp_a, dp_b, dp_idx          on-the-fly A/B registers and iteration index to the step stage
//   dp_w_nxt, dp_a_nxt, dp_b_nxt next residual / A / B from the step stage
//   done_valid, done_ready      result handshake
//   quotient, remainder         final A and final W
//   div_err                     divide-by-zero flag (DIVZERO_CHECK_EN only)
module srt4_div_seq
    import srt4_div_pkg::*;
#(
    parameter int N_ITER = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W_WIDTH-1:0]   dividend,
    input  logic [W_WIDTH-1:0]   divisor,
    output logic                 busy,
    output logic [W_WIDTH-1:0]   dp_w,
    output logic [2:0]           dp_q,
    output logic [W_WIDTH-1:0]   dp_d,
    output logic [AB_WIDTH-1:0]  dp_a,
    output logic [AB_WIDTH-1:0]  dp_b,
    output logic [IDX_WIDTH-1:0] dp_idx,
    input  logic [W_WIDTH-1:0]   dp_w_nxt,
    input  logic [AB_WIDTH-1:0]  dp_a_nxt,
    input  logic [AB_WIDTH-1:0]  dp_b_nxt,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [AB_WIDTH-1:0]  quotient,
`ifdef DIVZERO_CHECK_EN
    output logic                 div_err,
`endif
    output logic [W_WIDTH-1:0]   remainder
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(N_ITER - 1);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   last;
    logic   div_zero;
    logic [2:0] q_sel;

`ifdef DIVZERO_CHECK_EN
    assign div_zero = (divisor == '0);
`else
    assign div_zero = 1'b0;
`endif

    srt4_digit_sel u_digit_sel (
        .w (dp_w),
        .d (dp_d),
        .q (q_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = div_zero ? DONE : ITER;
                end
            end
            ITER: begin
                if (dp_idx == IDX_LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_w      <= '0;
            dp_d      <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_idx    <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIVZERO_CHECK_EN
            div_err   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                dp_w   <= dividend;
                dp_d   <= divisor;
                dp_a   <= '0;
                dp_b   <= '0;
                dp_idx <= '0;
            end else if (state == ITER) begin
                dp_w <= dp_w_nxt;
                dp_a <= dp_a_nxt;
                dp_b <= dp_b_nxt;
                // Index parks at the last value so it can never wrap.
                if (!last) begin
                    dp_idx <= dp_idx + IDX_WIDTH'(1);
                end
            end
            if (last) begin
                quotient  <= dp_a_nxt;
                remainder <= dp_w_nxt;
            end
`ifdef DIVZERO_CHECK_EN
            if (accept && div_zero) begin
                quotient  <= '1;
                remainder <= dividend;
                div_err   <= 1'b1;
            end else if (state == DONE && done_ready) begin
                div_err   <= 1'b0;
            end
`endif
        end
    end

    assign busy       = (state != IDLE);
    assign done_valid = (state == DONE);
    assign dp_q       = (state == ITER) ? q_sel : Q_Z;

endmodule

// File: tb/tb_srt4_div_seq.sv
// tb/tb_srt4_div_seq.sv - self-checking bench for srt4_div_seq with a behavioural step stage
module tb_srt4_div_seq;

    localparam int N = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done_ready = 1'b0;
    logic [21:0] dividend = '0;
    logic [21:0] divisor = '0;
    logic        busy;
    logic        done_valid;
    logic [21:0] dp_w, dp_d, dp_w_nxt, remainder;
    logic [2:0]  dp_q;
    logic [25:0] dp_a, dp_b, dp_a_nxt, dp_b_nxt, quotient;
    logic [3:0]  dp_idx;
`ifdef DIVZERO_CHECK_EN
    logic        div_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [2:0]  exp_dig [N];
    logic [25:0] exp_q;
    logic [21:0] exp_r;

    always #5 clk = ~clk;

    // Reference digit selection in plain integer arithmetic
    function automatic logic [2:0] ref_sel(input logic [21:0] w, input logic [21:0] d);
        int s, dd, h, t;
        s  = int'($signed({w[21], w[18:0], 2'b00}));
        dd = int'($signed(d));
        h  = dd >>> 1;
        t  = dd + h;
        if (s >= t)       return 3'b010;
        else if (s >= h)  return 3'b001;
        else if (s > -h)  return 3'b000;
        else if (s > -t)  return 3'b111;
        else              return 3'b110;
    endfunction

    function automatic logic [21:0] step_w(input logic [21:0] w, input logic [2:0] q, input logic [21:0] d);
        logic [21:0] s;
        s = {w[21], w[18:0], 2'b00};
        case (q)
            3'b010:  return s - {d[20:0], 1'b0};
            3'b001:  return s - d;
            3'b111:  return s + d;
            3'b110:  return s + {d[20:0], 1'b0};
            default: return s;
        endcase
    endfunction

    function automatic logic [25:0] step_a(input logic [25:0] a, input logic [25:0] b, input logic [2:0] q);
        return q[2] ? {b[23:0], q[1:0]} : {a[23:0], q[1:0]};
    endfunction

    function automatic logic [25:0] step_b(input logic [25:0] a, input logic [25:0] b, input logic [2:0] q);
        case (q)
            3'b010:  return {a[23:0], 2'b01};
            3'b001:  return {a[23:0], 2'b00};
            3'b111:  return {b[23:0], 2'b10};
            3'b110:  return {b[23:0], 2'b01};
            default: return {b[23:0], 2'b11};
        endcase
    endfunction

    // Behavioural step stage driven by the sequencer
    always_comb begin
        dp_w_nxt = step_w(dp_w, dp_q, dp_d);
        dp_a_nxt = step_a(dp_a, dp_b, dp_q);
        dp_b_nxt = step_b(dp_a, dp_b, dp_q);
    end

    srt4_div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .dp_w       (dp_w),
        .dp_q       (dp_q),
        .dp_d       (dp_d),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_idx     (dp_idx),
        .dp_w_nxt   (dp_w_nxt),
        .dp_a_nxt   (dp_a_nxt),
        .dp_b_nxt   (dp_b_nxt),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .quotient   (quotient),
`ifdef DIVZERO_CHECK_EN
        .div_err    (div_err),
`endif
        .remainder  (remainder)
    );

    task automatic model_run(input logic [21:0] x, input logic [21:0] y);
        logic [21:0] w;
        logic [25:0] a, b, an, bn;
        logic [2:0]  q;
        w = x; a = '0; b = '0;
        for (int i = 0; i < N; i++) begin
            q = ref_sel(w, y);
            exp_dig[i] = q;
            an = step_a(a, b, q);
            bn = step_b(a, b, q);
            w  = step_w(w, q, y);
            a  = an;
            b  = bn;
        end
        exp_q = a;
        exp_r = w;
    endtask

    task automatic accept_op(input logic [21:0] x, input logic [21:0] y);
        dividend = x;
        divisor  = y;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic handshake();
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
    endtask

    // Runs one operation to done_valid; lat is the cycle in which done_valid is first seen.
    task automatic run_op(input logic [21:0] x, input logic [21:0] y,
                          output int lat, output int dig_err, output int idx_err);
        model_run(x, y);
        accept_op(x, y);
        lat = 1; dig_err = 0; idx_err = 0;
        while (done_valid !== 1'b1 && lat <= 40) begin
            if (lat <= N) begin
                if (dp_q !== exp_dig[lat-1]) dig_err++;
                if (dp_idx !== 4'(lat-1)) idx_err++;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 1'b0 || done_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b done_valid=%b, required 0/0", busy, done_valid);
        end
        checks++;
        if (dp_q !== 3'b000) begin
            errors++; $display("FAIL reset_dp_q: got %b, required 000", dp_q);
        end
        checks++;
        if ({dp_w, dp_d, dp_a, dp_b, dp_idx} !== '0) begin
            errors++; $display("FAIL reset_dp: w=%h d=%h a=%h b=%h idx=%0d, required all 0", dp_w, dp_d, dp_a, dp_b, dp_idx);
        end
        checks++;
        if (quotient !== 26'h0 || remainder !== 22'h0) begin
            errors++; $display("FAIL reset_result: q=%h r=%h, required 0/0", quotient, remainder);
        end
`ifdef DIVZERO_CHECK_EN
        checks++;
        if (div_err !== 1'b0) begin
            errors++; $display("FAIL reset_div_err: got %b, required 0", div_err);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_dividend();
        int lat, de, ie;
        run_op(22'h000000, 22'h100000, lat, de, ie);
        checks++;
        if (lat !== 13) begin
            errors++; $display("FAIL zero_latency: got %0d, required 13", lat);
        end
        checks++;
        if (de !== 0 || exp_dig[0] !== 3'b000 || exp_dig[N-1] !== 3'b000) begin
            errors++; $display("FAIL zero_digits: %0d digit errors, required 0 and all digits 000", de);
        end
        checks++;
        if (ie !== 0) begin
            errors++; $display("FAIL zero_idx: %0d index errors, required 0 (idx 0..11)", ie);
        end
        checks++;
        if (quotient !== 26'h0 || remainder !== 22'h0) begin
            errors++; $display("FAIL zero_result: q=%h r=%h, required 0/0", quotient, remainder);
        end
        handshake();
    endtask

    task automatic test_random(input int n);
        int lat, de, ie;
        logic [21:0] x, y;
        for (int v = 0; v < n; v++) begin
            x = 22'($urandom);
            y = {2'b01, 20'($urandom)};
            run_op(x, y, lat, de, ie);
            checks++;
            if (lat !== 13 || de !== 0 || ie !== 0) begin
                errors++; $display("FAIL rand_seq %0d: x=%h y=%h lat=%0d dig_err=%0d idx_err=%0d, required 13/0/0", v, x, y, lat, de, ie);
            end
            checks++;
            if (quotient !== exp_q || remainder !== exp_r) begin
                errors++; $display("FAIL rand_result %0d: x=%h y=%h q=%h r=%h, required q=%h r=%h", v, x, y, quotient, remainder, exp_q, exp_r);
            end
            handshake();
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [21:0] x, y;
        x = 22'h0A1234;
        y = 22'h13579B;
        model_run(x, y);
        accept_op(x, y);
        lat = 1;
        while (dp_idx !== 4'd4 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        dividend = 22'h3FFFFF;
        divisor  = 22'h1FFFFF;
        start    = 1'b1;
        @(posedge clk); #1; lat++;
        start    = 1'b0;
        checks++;
        if (dp_d !== y || dp_idx !== 4'd5) begin
            errors++; $display("FAIL busy_start: dp_d=%h idx=%0d, required %h/5", dp_d, dp_idx, y);
        end
        while (done_valid !== 1'b1 && lat <= 40) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 13) begin
            errors++; $display("FAIL busy_start_latency: got %0d, required 13", lat);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done_valid !== 1'b1 || quotient !== exp_q || remainder !== exp_r || dp_d !== y) begin
            errors++; $display("FAIL done_start: valid=%b q=%h r=%h d=%h, required 1/%h/%h/%h", done_valid, quotient, remainder, dp_d, exp_q, exp_r, y);
        end
        handshake();
        checks++;
        if (done_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_start_release: valid=%b busy=%b, required 0/0", done_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done_valid !== 1'b0) begin
            errors++; $display("FAIL no_queue: busy=%b valid=%b, required 0/0", busy, done_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat, de, ie;
        logic [25:0] q0;
        logic [21:0] r0;
        run_op(22'h055555, 22'h1C0000, lat, de, ie);
        q0 = exp_q;
        r0 = exp_r;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done_valid !== 1'b1 || busy !== 1'b1 || quotient !== q0 || remainder !== r0) begin
                errors++; $display("FAIL hold_%0d: valid=%b busy=%b q=%h r=%h, required 1/1/%h/%h", c, done_valid, busy, quotient, remainder, q0, r0);
            end
        end
        handshake();
        checks++;
        if (done_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_release: valid=%b busy=%b, required 0/0", done_valid, busy);
        end
        checks++;
        if (quotient !== q0 || remainder !== r0) begin
            errors++; $display("FAIL idle_keep: q=%h r=%h, required %h/%h", quotient, remainder, q0, r0);
        end
        run_op(22'h3F0000, 22'h120000, lat, de, ie);
        checks++;
        if (lat !== 13 || de !== 0 || quotient !== exp_q || remainder !== exp_r) begin
            errors++; $display("FAIL after_hold: lat=%0d dig_err=%0d q=%h r=%h, required 13/0/%h/%h", lat, de, quotient, remainder, exp_q, exp_r);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat, de, ie;
        accept_op(22'h0ABCDE, 22'h1ABCDE);
        lat = 1;
        while (dp_idx !== 4'd5 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done_valid !== 1'b0 || dp_q !== 3'b000) begin
            errors++; $display("FAIL rst_mid_ctrl: busy=%b valid=%b q=%b, required 0/0/000", busy, done_valid, dp_q);
        end
        checks++;
        if ({dp_w, dp_d, dp_a, dp_b, dp_idx} !== '0 || quotient !== 26'h0 || remainder !== 22'h0) begin
            errors++; $display("FAIL rst_mid_regs: w=%h d=%h a=%h b=%h idx=%0d q=%h r=%h, required all 0", dp_w, dp_d, dp_a, dp_b, dp_idx, quotient, remainder);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(22'h012345, 22'h1F0F0F, lat, de, ie);
        checks++;
        if (lat !== 13 || de !== 0 || ie !== 0 || quotient !== exp_q || remainder !== exp_r) begin
            errors++; $display("FAIL rst_mid_fresh: lat=%0d dig_err=%0d idx_err=%0d q=%h r=%h, required 13/0/0/%h/%h", lat, de, ie, quotient, remainder, exp_q, exp_r);
        end
        handshake();
    endtask

    task automatic test_divzero();
        int lat, de, ie;
        run_op(22'h00ABCD, 22'h000000, lat, de, ie);
`ifdef DIVZERO_CHECK_EN
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL divzero_latency: got %0d, required 1", lat);
        end
        checks++;
        if (div_err !== 1'b1 || quotient !== 26'h3FFFFFF || remainder !== 22'h00ABCD) begin
            errors++; $display("FAIL divzero_result: err=%b q=%h r=%h, required 1/3ffffff/00abcd", div_err, quotient, remainder);
        end
        handshake();
        checks++;
        if (div_err !== 1'b0 || done_valid !== 1'b0) begin
            errors++; $display("FAIL divzero_clear: err=%b valid=%b, required 0/0", div_err, done_valid);
        end
`else
        checks++;
        if (lat !== 13 || de !== 0 || ie !== 0) begin
            errors++; $display("FAIL divzero_iter: lat=%0d dig_err=%0d idx_err=%0d, required 13/0/0", lat, de, ie);
        end
        checks++;
        if (quotient !== exp_q || remainder !== exp_r) begin
            errors++; $display("FAIL divzero_result: q=%h r=%h, required %h/%h", quotient, remainder, exp_q, exp_r);
        end
        handshake();
`endif
    endtask

    initial begin
        test_reset();
        test_zero_dividend();
        test_random(1000);
        test_start_ignored();
        test_backpressure();
        test_reset_mid();
        test_divzero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
